// File: rtl/y_line_writeback.sv
// y_line_writeback: read-modify-write of single 16-bit elements into the
// 256-bit Y line memory (single port, 1-cycle read latency).
// An all-ones element index is the end-of-stream marker: the block drains
// any pending line and pulses yW_done.
// Optional build macro YW_COALESCE_EN: keep the modified line in a tagged
// buffer so that further updates to the same line merge without a memory
// access; the line is written back on a line change or at the end marker.
module y_line_writeback #(
  parameter int DATA_W = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              yW_reqValid,
  output logic              yW_reqReady,
  input  logic [15:0]       yW_elemIdx,
  input  logic [DATA_W-1:0] yW_elemData,
  output logic [ADDR_W-1:0] yW_memAddr,
  output logic              yW_memRdEn,
  input  logic [LINE_W-1:0] yW_memRdData,
  output logic              yW_memWrEn,
  output logic [LINE_W-1:0] yW_memWrData,
  output logic              yW_busy,
  output logic              yW_done
);

  localparam int LANES  = LINE_W / DATA_W;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [ADDR_W-1:0] IDLE_ADDR = '1;
  localparam logic [15:0]       END_MARKER = 16'hFFFF;

`ifdef YW_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FLUSH, DONE} state_t;

  state_t              state, nextState;
  logic [ADDR_W-1:0]   reqLine;
  logic [LANE_W-1:0]   reqLane;
  logic [DATA_W-1:0]   reqData;
  logic                reqMarker;
  logic [LINE_W-1:0]   lineBuf;
  logic [ADDR_W-1:0]   bufTag;
  logic                bufValid;
  logic                bufDirty;

  // Index decode; bit 15 is dropped for ordinary requests.
  logic [ADDR_W-1:0]   inLine;
  logic [LANE_W-1:0]   inLane;
  logic                inMarker;
  logic                accept;
  logic                bufHit;
  logic [LINE_W-1:0]   mergedLine;

  assign inLine   = yW_elemIdx[LANE_W +: ADDR_W];
  assign inLane   = yW_elemIdx[LANE_W-1:0];
  assign inMarker = (yW_elemIdx == END_MARKER);
  assign accept   = yW_reqValid && (state == IDLE);
  assign bufHit   = COALESCE && bufValid && (bufTag == inLine) && !inMarker;

  // Fresh memory line with the requested lane replaced by the captured data.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    mergedLine = yW_memRdData;
    mergedLine[reqLane*DATA_W +: DATA_W] = reqData;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state selection.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (yW_reqValid) begin
          if (inMarker)      nextState = bufDirty ? FLUSH : DONE;
          else if (bufHit)   nextState = IDLE;
          else if (bufDirty) nextState = FLUSH;
          else               nextState = RD;
        end
      end
      RD:      nextState = WAIT;
      WAIT:    nextState = COALESCE ? IDLE : WR;
      WR:      nextState = IDLE;
      FLUSH:   nextState = reqMarker ? DONE : RD;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture and line buffer bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the line buffer is a plain register, so it is cleared on reset
      // to guarantee no partial update survives an aborted operation.
      reqLine   <= '0;
      reqLane   <= '0;
      reqData   <= '0;
      reqMarker <= 1'b0;
      lineBuf   <= '0;
      bufTag    <= '0;
      bufValid  <= 1'b0;
      bufDirty  <= 1'b0;
    end else begin
      if (accept) begin
        reqMarker <= inMarker;
        if (!inMarker) begin
          reqLine <= inLine;
          reqLane <= inLane;
          reqData <= yW_elemData;
        end
        if (bufHit) begin
          lineBuf[inLane*DATA_W +: DATA_W] <= yW_elemData;
          bufDirty <= 1'b1;
        end
      end
      unique case (state)
        WAIT: begin
          lineBuf  <= mergedLine;
          bufTag   <= reqLine;
          bufValid <= COALESCE;
          bufDirty <= COALESCE;
        end
        FLUSH, DONE: begin
          bufValid <= 1'b0;
          bufDirty <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and status outputs decoded from the state.
  always_comb begin
    yW_memAddr   = IDLE_ADDR;
    yW_memRdEn   = 1'b0;
    yW_memWrEn   = 1'b0;
    yW_memWrData = '0;
    yW_done      = 1'b0;
    unique case (state)
      RD: begin
        yW_memAddr = reqLine;
        yW_memRdEn = 1'b1;
      end
      WR: begin
        yW_memAddr   = reqLine;
        yW_memWrEn   = 1'b1;
        yW_memWrData = lineBuf;
      end
      FLUSH: begin
        yW_memAddr   = bufTag;
        yW_memWrEn   = 1'b1;
        yW_memWrData = lineBuf;
      end
      DONE:    yW_done = 1'b1;
      default: ;
    endcase
  end

  // Ready only in IDLE; busy while a request is in flight or the buffer is dirty.
  assign yW_reqReady = (state == IDLE);
  assign yW_busy     = ((state != IDLE) && (state != DONE)) || bufDirty;

endmodule
